e_muldiv_unit: RTL

Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core. It supersedes the fixed 32-bit HI/LO block. It adds configurable operand width and per-class latency, signed/unsigned multiply-accumulate (madd/maddu/msub/msubu), a completion pulse, and a flush input that aborts an in-flight operation without touching HI/LO. The E stage feeds forwarded rs/rt operands. The hazard unit stalls any HI/LO-dependent instruction in D while `Busy` is high or `Start` is asserted.

---
 rtl/e_muldiv_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/e_muldiv_unit.sv
// rtl/e_muldiv_unit.sv - multi-cycle multiply/divide unit with HI/LO registers for the E stage
// Fixed-latency mult/div/madd/msub with flush abort; the result is formed from latched operands at commit.
module e_muldiv_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [3:0]       HILOOp,
   input  logic             Flush,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] D2,
   input  logic             ReadSel,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Out
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_done;

   logic               w_mul_signed;
   logic               w_div_signed;
   logic [2*WIDTH-1:0] w_a_ext;
   logic [2*WIDTH-1:0] w_b_ext;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_hilo;
   logic [2*WIDTH-1:0] w_acc_add;
   logic [2*WIDTH-1:0] w_acc_sub;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH-1:0]   w_b_safe;
   logic [WIDTH-1:0]   w_q_mag;
   logic [WIDTH-1:0]   w_r_mag;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_new_hi;
   logic [WIDTH-1:0]   w_new_lo;
   logic               w_is_multi;
   logic               w_is_div;

   // Product is formed in 2*WIDTH bits so signed and unsigned share one multiplier.
   assign w_mul_signed = (r_op == OP_MULT) || (r_op == OP_MADD) || (r_op == OP_MSUB);
   assign w_a_ext      = {{WIDTH{w_mul_signed & r_a[WIDTH-1]}}, r_a};
   assign w_b_ext      = {{WIDTH{w_mul_signed & r_b[WIDTH-1]}}, r_b};
   assign w_prod       = w_a_ext * w_b_ext;
   assign w_hilo       = {r_hi, r_lo};
   assign w_acc_add    = w_hilo + w_prod;
   assign w_acc_sub    = w_hilo - w_prod;

   // Signed division on magnitudes; MIN/-1 falls out as MIN with remainder 0.
   assign w_div_signed = (r_op == OP_DIV);
   assign w_a_neg      = w_div_signed & r_a[WIDTH-1];
   assign w_b_neg      = w_div_signed & r_b[WIDTH-1];
   assign w_a_mag      = w_a_neg ? (-r_a) : r_a;
   assign w_b_mag      = w_b_neg ? (-r_b) : r_b;
   assign w_b_safe     = (r_b == '0) ? WIDTH'(1) : w_b_mag;
   assign w_q_mag      = w_a_mag / w_b_safe;
   assign w_r_mag      = w_a_mag % w_b_safe;
   assign w_quot       = (w_a_neg ^ w_b_neg) ? (-w_q_mag) : w_q_mag;
   assign w_rem        = w_a_neg ? (-w_r_mag) : w_r_mag;

   always_comb begin
      w_new_hi = r_hi;
      w_new_lo = r_lo;
      case (r_op)
         OP_MULT, OP_MULTU: {w_new_hi, w_new_lo} = w_prod;
         OP_MADD, OP_MADDU: {w_new_hi, w_new_lo} = w_acc_add;
         OP_MSUB, OP_MSUBU: {w_new_hi, w_new_lo} = w_acc_sub;
         OP_DIV, OP_DIVU: begin
            if (r_b == '0) begin
               w_new_lo = '1;
               w_new_hi = r_a;
            end else begin
               w_new_lo = w_quot;
               w_new_hi = w_rem;
            end
         end
         default: ;
      endcase
   end

   assign w_is_div   = (HILOOp == OP_DIV) || (HILOOp == OP_DIVU);
   assign w_is_multi = w_is_div || (HILOOp == OP_MULT) || (HILOOp == OP_MULTU) ||
                       (HILOOp >= OP_MADD && HILOOp <= OP_MSUBU);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (Start && !Flush) begin
                  if (HILOOp == OP_MTHI) begin
                     r_hi <= D1;
                  end else if (HILOOp == OP_MTLO) begin
                     r_lo <= D1;
                  end else if (w_is_multi) begin
                     r_op    <= HILOOp;
                     r_a     <= D1;
                     r_b     <= D2;
                     r_cnt   <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (Flush) begin
                  r_state <= S_IDLE;
               end else if (r_cnt == CW'(1)) begin
                  r_hi    <= w_new_hi;
                  r_lo    <= w_new_lo;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign Busy = (r_state == S_RUN);
   assign Done = r_done;
   assign Out  = ReadSel ? r_hi : r_lo;

endmodule
